fir_sequencer: RTL and testbench

- Control FSM for the FIR datapath. Computes y[n] = sum h[k]*x[n-k] over input sample RAM and coefficient RAM, then writes results to output RAM.
- While running, takes both AXI-side RAM address muxes, so AXI cannot access the RAMs mid-run.
- Instantiated next to the AXI slave and the RAMs; replaces the tied-off FSM signals at top level.

---
 rtl/fir_pkg.sv | 51 +++++
 rtl/fir_mac.sv | 48 ++++
 rtl/fir_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_fir_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared definitions for the FIR sequencer.
//   - default width constants for addresses, samples, coefficients,
//     accumulator and output
//   - COEF_FRAC: fractional bits of the Q1.COEF_FRAC coefficients
//   - state_e: sequencer FSM states
//   - sat_shift(): accumulator -> output sample conversion
// Optional build macro: FIR_ROUND_EN (round half up before the shift;
// when undefined the shift truncates toward minus infinity).
package fir_pkg;

    localparam int ADDR_WIDTH = 13;
    localparam int DATA_WIDTH = 16;
    localparam int COEF_WIDTH = 16;
    localparam int COEF_FRAC  = 15;
    localparam int ACC_WIDTH  = 40;
    localparam int OUT_WIDTH  = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_MAC   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // One guard bit above the accumulator so the rounding add cannot wrap.
    localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH+1)'(2**(OUT_WIDTH-1) - 1);
    localparam logic signed [ACC_WIDTH:0] SAT_MIN = -((ACC_WIDTH+1)'(2**(OUT_WIDTH-1)));
`ifdef FIR_ROUND_EN
    localparam logic signed [ACC_WIDTH:0] RND_HALF = (ACC_WIDTH+1)'(2**(COEF_FRAC-1));
`endif

    // Scale the accumulator back to sample units and clamp to OUT_WIDTH.
    function automatic logic signed [OUT_WIDTH-1:0] sat_shift(input logic signed [ACC_WIDTH-1:0] acc);
        logic signed [ACC_WIDTH:0] t;
        t = {acc[ACC_WIDTH-1], acc};
`ifdef FIR_ROUND_EN
        t = t + RND_HALF;
`endif
        t = t >>> COEF_FRAC;
        if (t > SAT_MAX) begin
            return SAT_MAX[OUT_WIDTH-1:0];
        end else if (t < SAT_MIN) begin
            return SAT_MIN[OUT_WIDTH-1:0];
        end else begin
            return t[OUT_WIDTH-1:0];
        end
    endfunction

endpackage

// File: rtl/fir_mac.sv
// fir_mac: registered signed multiply-accumulate.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clear       zero the accumulator (wins over valid_in)
//   valid_in    add a*b to the accumulator this cycle
//   a, b        signed operands (sample, coefficient)
//   acc         accumulator value
module fir_mac #(
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         valid_in,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [COEF_WIDTH-1:0] b,
    output logic signed [ACC_WIDTH-1:0]  acc
);

    localparam int PROD_WIDTH = DATA_WIDTH + COEF_WIDTH;

    logic signed [PROD_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]  acc_d, acc_q;

    assign prod = a * b;

    always_comb begin
        acc_d = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (valid_in) begin
            acc_d = acc_q + {{(ACC_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/fir_sequencer.sv
// fir_sequencer: control FSM computing y[n] = sum_k h[k]*x[n-k] from the
// sample and coefficient RAMs and writing y to the output RAM.
// Ports:
//   a_clk, a_rst_n          clock, asynchronous active-low reset
//   start                   pulse; begins a run when idle
//   n_samples, n_taps       run geometry, latched on start
//   sample_addr/sample_data input-RAM read port (data one cycle late)
//   coef_addr/coef_data     coefficient-RAM read port (data one cycle late)
//   sel_mux_wej/sel_mux_wyj RAM address muxes owned by the FSM while busy
//   out_addr/out_data/out_wr output-RAM write port
//   busy, done              run in progress / end-of-run pulse
// Optional build macro: FIR_ROUND_EN (see fir_pkg::sat_shift).
module fir_sequencer
    import fir_pkg::*;
#(
    parameter int ADDR_WIDTH = fir_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = fir_pkg::DATA_WIDTH,
    parameter int COEF_WIDTH = fir_pkg::COEF_WIDTH,
    parameter int COEF_FRAC  = fir_pkg::COEF_FRAC,
    parameter int ACC_WIDTH  = fir_pkg::ACC_WIDTH,
    parameter int OUT_WIDTH  = fir_pkg::OUT_WIDTH
) (
    input  logic                  a_clk,
    input  logic                  a_rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   n_samples,
    input  logic [ADDR_WIDTH:0]   n_taps,
    output logic [ADDR_WIDTH-1:0] sample_addr,
    input  logic [DATA_WIDTH-1:0] sample_data,
    output logic [ADDR_WIDTH-1:0] coef_addr,
    input  logic [COEF_WIDTH-1:0] coef_data,
    output logic                  sel_mux_wej,
    output logic                  sel_mux_wyj,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_wr,
    output logic                  busy,
    output logic                  done
);

    // sat_shift is built on the package widths; refuse a mismatched build.
    if (ACC_WIDTH != fir_pkg::ACC_WIDTH || OUT_WIDTH != fir_pkg::OUT_WIDTH ||
        COEF_FRAC != fir_pkg::COEF_FRAC) begin : gen_width_check
        $error("fir_sequencer: ACC_WIDTH/OUT_WIDTH/COEF_FRAC must match fir_pkg");
    end

    localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH+1)'(1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   n_q, n_d;       // current output index
    logic [ADDR_WIDTH:0]   k_q, k_d;       // current tap index
    logic [ADDR_WIDTH:0]   len_q, len_d;   // taps used for this output
    logic [ADDR_WIDTH:0]   ns_q, ns_d;
    logic [ADDR_WIDTH:0]   nt_q, nt_d;
    logic                  vld_q, vld_d;   // read data on the RAM ports is live
    logic                  busy_q, busy_d;
    logic                  wr_q, wr_d;
    logic                  done_q, done_d;
    logic                  mac_clear;
    logic [ADDR_WIDTH:0]   last_tap;
    logic signed [ACC_WIDTH-1:0] acc;

    assign last_tap = nt_q - ONE;

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        k_d       = k_q;
        len_d     = len_q;
        ns_d      = ns_q;
        nt_d      = nt_q;
        mac_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (n_samples == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        ns_d    = n_samples;
                        nt_d    = n_taps;
                        n_d     = '0;
                        state_d = ST_CLEAR;
                    end
                end
            end
            ST_CLEAR: begin
                mac_clear = 1'b1;
                k_d       = '0;
                if (nt_q == '0) begin
                    len_d   = '0;
                    state_d = ST_DRAIN;
                end else begin
                    // Early outputs have fewer than n_taps valid history samples.
                    len_d   = ((n_q < last_tap) ? n_q : last_tap) + ONE;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                k_d = k_q + ONE;
                if (k_q == len_q - ONE) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                n_d = n_q + ONE;
                if (n_q + ONE == ns_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered status outputs track the state being entered.
        vld_d  = (state_q == ST_MAC);
        busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
        wr_d   = (state_d == ST_WRITE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge a_clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            k_q     <= '0;
            len_q   <= '0;
            ns_q    <= '0;
            nt_q    <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            wr_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
            len_q   <= len_d;
            ns_q    <= ns_d;
            nt_q    <= nt_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            wr_q    <= wr_d;
            done_q  <= done_d;
        end
    end

    fir_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .COEF_WIDTH (COEF_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk      (a_clk),
        .rst_n    (a_rst_n),
        .clear    (mac_clear),
        .valid_in (vld_q),
        .a        (sample_data),
        .b        (coef_data),
        .acc      (acc)
    );

    // Addresses are held at zero outside the phases that use them.
    assign sample_addr = (state_q == ST_MAC) ? ADDR_WIDTH'(n_q - k_q) : '0;
    assign coef_addr   = (state_q == ST_MAC) ? ADDR_WIDTH'(k_q) : '0;
    assign out_addr    = wr_q ? ADDR_WIDTH'(n_q) : '0;
    assign out_data    = wr_q ? sat_shift(acc) : '0;
    assign out_wr      = wr_q;
    assign busy        = busy_q;
    assign sel_mux_wej = busy_q;
    assign sel_mux_wyj = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_fir_sequencer.sv
module tb_fir_sequencer;

    localparam int AW = 13;

    logic          a_clk = 1'b0;
    logic          a_rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   n_samples = '0;
    logic [AW:0]   n_taps = '0;
    logic [AW-1:0] sample_addr, coef_addr, out_addr;
    logic [15:0]   sample_data, coef_data, out_data;
    logic          sel_mux_wej, sel_mux_wyj, out_wr, busy, done;

    fir_sequencer dut (
        .a_clk       (a_clk),
        .a_rst_n     (a_rst_n),
        .start       (start),
        .n_samples   (n_samples),
        .n_taps      (n_taps),
        .sample_addr (sample_addr),
        .sample_data (sample_data),
        .coef_addr   (coef_addr),
        .coef_data   (coef_data),
        .sel_mux_wej (sel_mux_wej),
        .sel_mux_wyj (sel_mux_wyj),
        .out_addr    (out_addr),
        .out_data    (out_data),
        .out_wr      (out_wr),
        .busy        (busy),
        .done        (done)
    );

    always #5 a_clk = ~a_clk;

    // RAM models with one-cycle registered read.
    logic [15:0] sample_mem [0:15];
    logic [15:0] coef_mem   [0:15];
    always @(posedge a_clk) begin
        sample_data <= sample_mem[sample_addr[3:0]];
        coef_data   <= coef_mem[coef_addr[3:0]];
    end

    // Activity monitor sampled on the falling edge.
    int          busy_cnt = 0, done_cnt = 0, wr_cnt = 0, sel_cnt = 0;
    logic [AW-1:0] wr_addr [0:63];
    logic [15:0]   wr_data [0:63];
    always @(negedge a_clk) begin
        if (busy) busy_cnt <= busy_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (sel_mux_wej || sel_mux_wyj) sel_cnt <= sel_cnt + 1;
        if (out_wr) begin
            if (wr_cnt < 64) begin
                wr_addr[wr_cnt] <= out_addr;
                wr_data[wr_cnt] <= out_data;
            end
            wr_cnt <= wr_cnt + 1;
        end
    end

    int vectors = 0;
    int miscompares = 0;
    int exp_y [8];
    int latency;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick();
        @(negedge a_clk);
        #1;
    endtask

    task automatic clear_mems();
        for (int i = 0; i < 16; i++) begin
            sample_mem[i] = '0;
            coef_mem[i]   = '0;
        end
    endtask

    // One run: pulse start, optionally re-pulse it mid-run, wait for done,
    // then check cycle counts and every output write.
    task automatic run(input string name, input int ns, input int nt,
                       input int restart_at, input int exp_busy);
        int  b0, w0, d0, s0;
        bit  seen;
        b0 = busy_cnt; w0 = wr_cnt; d0 = done_cnt; s0 = sel_cnt;
        n_samples = (AW+1)'(ns);
        n_taps    = (AW+1)'(nt);
        start     = 1'b1;
        tick();
        start     = 1'b0;
        seen      = 1'b0;
        latency   = -1;
        for (int i = 0; i < 300; i++) begin
            if (done_cnt != d0) begin
                seen    = 1'b1;
                latency = i;
                break;
            end
            tick();
            start = (i == restart_at);
        end
        start = 1'b0;
        tick();
        tick();
        check({name, ".done_seen"}, int'(seen), 1);
        check({name, ".done_pulses"}, done_cnt - d0, 1);
        check({name, ".busy_cycles"}, busy_cnt - b0, exp_busy);
        check({name, ".sel_cycles"}, sel_cnt - s0, exp_busy);
        check({name, ".writes"}, wr_cnt - w0, ns);
        for (int i = 0; i < ns && i < 8; i++) begin
            check($sformatf("%s.addr%0d", name, i), int'(wr_addr[w0+i]), i);
            check($sformatf("%s.y%0d", name, i), int'($signed(wr_data[w0+i])), exp_y[i]);
        end
    endtask

    task automatic load_impulse3();
        clear_mems();
        coef_mem[0] = 16'h2000; coef_mem[1] = 16'h4000; coef_mem[2] = 16'h2000;
        sample_mem[0] = 16'd4;
        exp_y[0] = 1; exp_y[1] = 2; exp_y[2] = 1; exp_y[3] = 0;
    endtask

    initial begin
        int w0, b0;
        clear_mems();
        #1;
        check("reset.ctrl", int'({busy, done, out_wr, sel_mux_wej, sel_mux_wyj}), 0);
        check("reset.addr", int'(sample_addr | coef_addr | out_addr), 0);
        check("reset.data", int'(out_data), 0);
        tick();
        tick();
        a_rst_n = 1'b1;
        tick();

        // Single tap of 0.5.
        clear_mems();
        coef_mem[0] = 16'h4000;
        sample_mem[0] = 16'd100; sample_mem[1] = 16'hFF38; sample_mem[2] = 16'd7;
        exp_y[0] = 50; exp_y[1] = -100;
`ifdef FIR_ROUND_EN
        exp_y[2] = 4;
`else
        exp_y[2] = 3;
`endif
        run("tap1", 3, 1, -1, 12);

        // Three-tap impulse response.
        load_impulse3();
        run("imp3", 4, 3, -1, 21);

        // Positive saturation.
        clear_mems();
        coef_mem[0] = 16'h7FFF; coef_mem[1] = 16'h7FFF;
        sample_mem[0] = 16'h7FFF; sample_mem[1] = 16'h7FFF;
        exp_y[0] = 32766; exp_y[1] = 32767;
        run("satp", 2, 2, -1, 9);

        // Negative saturation.
        sample_mem[0] = 16'h8000; sample_mem[1] = 16'h8000;
        exp_y[0] = -32767; exp_y[1] = -32768;
        run("satn", 2, 2, -1, 9);

        // Zero-length run: immediate done, nothing else moves.
        run("empty", 0, 3, -1, 0);
        check("empty.latency", latency, 0);

        // Second start mid-run must be ignored.
        load_impulse3();
        run("restart", 4, 3, 5, 21);

        // Reset during MAC of sample 2.
        load_impulse3();
        w0 = wr_cnt;
        n_samples = (AW+1)'(4);
        n_taps    = (AW+1)'(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100 && (wr_cnt - w0) < 2; i++) tick();
        tick();
        tick();
        check("midrst.busy_before", int'(busy), 1);
        a_rst_n = 1'b0;
        #1;
        check("midrst.ctrl", int'({busy, done, out_wr, sel_mux_wej, sel_mux_wyj}), 0);
        check("midrst.addr", int'(sample_addr | coef_addr | out_addr), 0);
        check("midrst.data", int'(out_data), 0);
        w0 = wr_cnt;
        b0 = busy_cnt;
        for (int i = 0; i < 4; i++) tick();
        a_rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("midrst.no_writes", wr_cnt - w0, 0);
        check("midrst.no_busy", busy_cnt - b0, 0);
        run("after_rst", 4, 3, -1, 21);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
